// File: rtl/dsp_mac_pkg.sv
// Shared types for the DSP48A1 multiply-accumulate sequencer: OPMODE codes, FSM states, pipeline tags.
package dsp_mac_pkg;

  // X=M, Z=0 starts a fresh sum; X=M, Z=P keeps accumulating
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    HOLD
  } state_t;

  typedef struct packed {
    logic vld;
    logic first;
  } tag_t;

endpackage

// File: rtl/dsp_mac_ctrl_if.sv
// Operand stream in and dot-product result out; the slave side is the sequencer.
// res_ovf is present only when DSP_MAC_OVF_CHK_EN is defined.
interface dsp_mac_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_data;
`ifdef DSP_MAC_OVF_CHK_EN
  logic        res_ovf;

  modport master (output in_valid, in_a, in_b, res_ready,
                  input  in_ready, res_valid, res_data, res_ovf);
  modport slave  (input  in_valid, in_a, in_b, res_ready,
                  output in_ready, res_valid, res_data, res_ovf);
`else
  modport master (output in_valid, in_a, in_b, res_ready,
                  input  in_ready, res_valid, res_data);
  modport slave  (input  in_valid, in_a, in_b, res_ready,
                  output in_ready, res_valid, res_data);
`endif
endinterface

// File: rtl/dsp_mac_tagpipe.sv
// Per-issue-cycle {vld, first} shift register tracking operands through the slice A1/B1 and M registers.
// Latency: taps at MUL_LAT-1 (OPMODE load) and MUL_LAT (CEP); always shifts, no backpressure.
// Synchronous clear drops every tag in flight.
module dsp_mac_tagpipe
  import dsp_mac_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic clk,
  input  logic clr,
  input  tag_t tag_in,
  output tag_t tap_opm,
  output logic tap_p_vld
);

  // sr[k] holds the tag issued k+1 cycles ago
  tag_t sr [MUL_LAT];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < MUL_LAT; i++) sr[i] <= '0;
    end else begin
      sr[0] <= tag_in;
      for (int i = 1; i < MUL_LAT; i++) sr[i] <= sr[i-1];
    end
  end

  assign tap_p_vld = sr[MUL_LAT-1].vld;

  generate
    if (MUL_LAT == 1) begin : g_tap_in
      assign tap_opm = tag_in;
    end else begin : g_tap_sr
      assign tap_opm = sr[MUL_LAT-2];
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_ctrl.sv
// Feeds operand pairs into one DSP48A1 slice and returns the VEC_LEN-term dot product.
// Latency: last beat accepted in cycle L gives res_valid in L+MUL_LAT+3; result held until res_ready.
// Optional DSP_MAC_OVF_CHK_EN adds res_ovf, a sticky carry-out flag per vector.
module dsp_mac_ctrl
  import dsp_mac_pkg::*;
#(
  parameter int VEC_LEN = 8,
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  dsp_mac_ctrl_if.slave strm,
  output logic [17:0]   dsp_a,
  output logic [17:0]   dsp_b,
  output logic          dsp_ce_ab,
  output logic          dsp_cem,
  output logic [7:0]    dsp_opmode,
  output logic          dsp_ce_opmode,
  output logic          dsp_cep,
  output logic          dsp_rstp,
  input  logic [47:0]   dsp_p,
  input  logic          dsp_carryout
);

  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(VEC_LEN - 1);
  // P is loaded at the end of the last CEP cycle and is readable one cycle later
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MUL_LAT + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             issue_first;
  tag_t             tag_in;
  tag_t             tap_opm;
  logic             tap_p_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      issue_first    <= 1'b0;
      strm.in_ready  <= 1'b0;
      strm.res_valid <= 1'b0;
      strm.res_data  <= '0;
      dsp_a          <= '0;
      dsp_b          <= '0;
      dsp_ce_ab      <= 1'b0;
      dsp_rstp       <= 1'b1;
    end else begin
      dsp_ce_ab <= 1'b0;
      case (state)
        IDLE: begin
          state         <= FEED;
          cnt           <= '0;
          dsp_rstp      <= 1'b0;
          strm.in_ready <= 1'b1;
        end
        FEED: begin
          if (strm.in_valid && strm.in_ready) begin
            dsp_a       <= strm.in_a;
            dsp_b       <= strm.in_b;
            dsp_ce_ab   <= 1'b1;
            issue_first <= (cnt == '0);
            if (cnt == LAST_BEAT) begin
              state         <= DRAIN;
              cnt           <= '0;
              strm.in_ready <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state          <= HOLD;
            cnt            <= '0;
            strm.res_data  <= dsp_p;
            strm.res_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (strm.res_ready) begin
            state          <= IDLE;
            strm.res_valid <= 1'b0;
            dsp_rstp       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tag_in = '{vld: dsp_ce_ab, first: issue_first};

  dsp_mac_tagpipe #(.MUL_LAT(MUL_LAT)) u_tagpipe (
    .clk       (clk),
    .clr       (rst),
    .tag_in    (tag_in),
    .tap_opm   (tap_opm),
    .tap_p_vld (tap_p_vld)
  );

  // Bubble products still land in M; leaving CEP low keeps them out of P
  assign dsp_cem       = (state != IDLE);
  assign dsp_ce_opmode = tap_opm.vld;
  assign dsp_opmode    = tap_opm.vld ? (tap_opm.first ? OPM_FIRST : OPM_ACC) : 8'h00;
  assign dsp_cep       = tap_p_vld;

`ifdef DSP_MAC_OVF_CHK_EN
  logic cep_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cep_d        <= 1'b0;
      strm.res_ovf <= 1'b0;
    end else begin
      cep_d <= dsp_cep;
      if (state == IDLE)              strm.res_ovf <= 1'b0;
      else if (cep_d && dsp_carryout) strm.res_ovf <= 1'b1;
    end
  end
`else
  logic carry_unused;
  assign carry_unused = dsp_carryout;
`endif

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Directed bench for dsp_mac_ctrl (VEC_LEN=4) with a behavioural DSP48A1 MAC-path model.
module tb_dsp_mac_ctrl;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] dsp_a, dsp_b;
  logic        dsp_ce_ab, dsp_cem, dsp_ce_opmode, dsp_cep, dsp_rstp;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;
  logic        dsp_carryout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cep_cnt = 0;
  int first_cnt = 0;
  int bad_opm = 0;
  logic force_co = 1'b0;

  dsp_mac_ctrl_if strm ();

  dsp_mac_ctrl #(.VEC_LEN(4), .MUL_LAT(MUL_LAT), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .strm          (strm),
    .dsp_a         (dsp_a),
    .dsp_b         (dsp_b),
    .dsp_ce_ab     (dsp_ce_ab),
    .dsp_cem       (dsp_cem),
    .dsp_opmode    (dsp_opmode),
    .dsp_ce_opmode (dsp_ce_opmode),
    .dsp_cep       (dsp_cep),
    .dsp_rstp      (dsp_rstp),
    .dsp_p         (dsp_p),
    .dsp_carryout  (dsp_carryout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slice model: A1/B1 -> M -> post-adder P, registered OPMODE, X from M, Z from P or zero
  logic [17:0] a1 = '0, b1 = '0;
  logic [35:0] m_q = '0;
  logic [7:0]  opm_q = '0;
  logic [47:0] p_q = '0;
  logic        co_q = 1'b0;
  logic [48:0] sum;

  assign sum = {1'b0, (opm_q[1:0] == 2'b01) ? {12'd0, m_q} : 48'd0}
             + {1'b0, (opm_q[3:2] == 2'b10) ? p_q : 48'd0};

  always @(posedge clk) begin
    if (dsp_ce_ab) begin a1 <= dsp_a; b1 <= dsp_b; end
    if (dsp_cem) m_q <= a1 * b1;
    if (dsp_ce_opmode) opm_q <= dsp_opmode;
    if (dsp_rstp) begin
      p_q  <= '0;
      co_q <= 1'b0;
    end else if (dsp_cep) begin
      {co_q, p_q} <= sum | {force_co, 48'd0};
    end
  end

  assign dsp_p = p_q;
  assign dsp_carryout = co_q;

  always @(negedge clk) begin
    if (dsp_cep) cep_cnt++;
    if (dsp_ce_opmode && dsp_opmode == 8'h01) first_cnt++;
    if (dsp_ce_opmode && dsp_opmode != 8'h01 && dsp_opmode != 8'h09) bad_opm++;
  end

  typedef struct {
    logic [3:0][17:0] a;
    logic [3:0][17:0] b;
    int               gap;
    int               hold;
    logic             fco;
    logic             ovf;
    logic [47:0]      exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int t;
    int l_cyc;
    l_cyc = 0;
    cep_cnt = 0;
    first_cnt = 0;
    bad_opm = 0;
    strm.res_ready = (v.hold == 0);
    force_co = v.fco;
    for (int i = 0; i < 4; i++) begin
      if (i == 2 && v.gap > 0) begin
        strm.in_valid = 1'b0;
        repeat (v.gap) tick();
      end
      strm.in_valid = 1'b1;
      strm.in_a = v.a[i];
      strm.in_b = v.b[i];
      t = 0;
      while (!strm.in_ready && t < 100) begin tick(); t++; end
      chk({tag, " accept_timeout"}, 48'(t < 100), 48'd1);
      l_cyc = cyc;
      tick();
    end
    strm.in_valid = 1'b0;
    t = 0;
    while (!strm.res_valid && t < 100) begin tick(); t++; end
    chk({tag, " result_timeout"}, 48'(t < 100), 48'd1);
    chk({tag, " latency"}, 48'(cyc - l_cyc), 48'(MUL_LAT + 3));
    chk({tag, " res_data"}, strm.res_data, v.exp);
    chk({tag, " cep_pulses"}, 48'(cep_cnt), 48'd4);
    chk({tag, " first_opmodes"}, 48'(first_cnt), 48'd1);
    chk({tag, " bad_opmodes"}, 48'(bad_opm), 48'd0);
    chk({tag, " in_ready_in_hold"}, 48'(strm.in_ready), 48'd0);
    chk({tag, " cem_in_hold"}, 48'(dsp_cem), 48'd1);
`ifdef DSP_MAC_OVF_CHK_EN
    chk({tag, " res_ovf"}, 48'(strm.res_ovf), 48'(v.ovf));
`endif
    for (int k = 0; k < v.hold; k++) begin
      tick();
      chk({tag, " hold_valid"}, 48'(strm.res_valid), 48'd1);
      chk({tag, " hold_data"}, strm.res_data, v.exp);
      chk({tag, " hold_in_ready"}, 48'(strm.in_ready), 48'd0);
    end
    strm.res_ready = 1'b1;
    tick();
    chk({tag, " idle_valid"}, 48'(strm.res_valid), 48'd0);
    chk({tag, " idle_rstp"}, 48'(dsp_rstp), 48'd1);
    chk({tag, " idle_cem"}, 48'(dsp_cem), 48'd0);
    tick();
    chk({tag, " feed_ready"}, 48'(strm.in_ready), 48'd1);
    chk({tag, " feed_rstp"}, 48'(dsp_rstp), 48'd0);
`ifdef DSP_MAC_OVF_CHK_EN
    chk({tag, " ovf_cleared"}, 48'(strm.res_ovf), 48'd0);
`endif
    force_co = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t ab;
    // Packed beat lists are written last-beat-first: a[0] is the rightmost element
    tbl[0] = '{{18'd4, 18'd3, 18'd2, 18'd1}, {18'd8, 18'd7, 18'd6, 18'd5}, 0, 0, 1'b0, 1'b0, 48'd70};
    tbl[1] = '{{18'd4, 18'd3, 18'd2, 18'd1}, {18'd8, 18'd7, 18'd6, 18'd5}, 2, 0, 1'b0, 1'b0, 48'd70};
    tbl[2] = '{{4{18'd1}}, {4{18'd1}}, 0, 0, 1'b0, 1'b0, 48'd4};
    tbl[3] = '{{4{18'd2}}, {4{18'd3}}, 0, 0, 1'b0, 1'b0, 48'd24};
    tbl[4] = '{{18'd4, 18'd3, 18'd2, 18'd1}, {18'd8, 18'd7, 18'd6, 18'd5}, 0, 10, 1'b0, 1'b0, 48'd70};
    tbl[5] = '{{18'd7, 18'd65535, 18'd0, 18'd100}, {18'd262143, 18'd3, 18'd9, 18'd200}, 0, 0, 1'b0, 1'b0, 48'd2051606};
    tbl[6] = '{{4{18'h3FFFF}}, {4{18'h3FFFF}}, 0, 0, 1'b0, 1'b0, 48'h003F_FFE0_0004};
    tbl[7] = '{{4{18'h3FFFF}}, {4{18'h3FFFF}}, 1, 0, 1'b1, 1'b1, 48'h003F_FFE0_0004};
    ab     = '{{4{18'd3}}, {4{18'd3}}, 0, 0, 1'b0, 1'b0, 48'd36};

    strm.in_valid = 1'b0;
    strm.in_a = '0;
    strm.in_b = '0;
    strm.res_ready = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    chk("rst in_ready", 48'(strm.in_ready), 48'd0);
    chk("rst res_valid", 48'(strm.res_valid), 48'd0);
    chk("rst res_data", strm.res_data, 48'd0);
    chk("rst dsp_a", 48'(dsp_a), 48'd0);
    chk("rst dsp_b", 48'(dsp_b), 48'd0);
    chk("rst ce_ab", 48'(dsp_ce_ab), 48'd0);
    chk("rst cem", 48'(dsp_cem), 48'd0);
    chk("rst opmode", 48'(dsp_opmode), 48'd0);
    chk("rst ce_opmode", 48'(dsp_ce_opmode), 48'd0);
    chk("rst cep", 48'(dsp_cep), 48'd0);
    chk("rst rstp", 48'(dsp_rstp), 48'd1);
    rst = 1'b0;
    tick();
    chk("post_rst in_ready", 48'(strm.in_ready), 48'd1);
    chk("post_rst rstp", 48'(dsp_rstp), 48'd0);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Abort a vector after two beats, then a clean vector must carry no residue
    strm.res_ready = 1'b1;
    strm.in_valid = 1'b1;
    strm.in_a = 18'd9;
    strm.in_b = 18'd9;
    repeat (2) tick();
    strm.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort in_ready", 48'(strm.in_ready), 48'd0);
    chk("abort ce_ab", 48'(dsp_ce_ab), 48'd0);
    chk("abort cep", 48'(dsp_cep), 48'd0);
    chk("abort ce_opmode", 48'(dsp_ce_opmode), 48'd0);
    chk("abort rstp", 48'(dsp_rstp), 48'd1);
    run_vec(ab, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
